// File: rtl/iob_bridge_pkg.sv
// Shared definitions for the native-to-IOb bridge.
//   bridge_state_e : request FSM encoding (IDLE=0 ... ERR=4)
//   bridge_dbg_t   : debug view of the FSM exported by the bridge
//   DECERR_RDATA   : read data returned with an errored completion
//   sel_w_f        : width of the address MSB field that selects a slave
package iob_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RDATA = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } bridge_state_e;

  typedef struct packed {
    bridge_state_e state;
    logic          instr;
  } bridge_dbg_t;

  localparam int DECERR_RDATA = 0;

  // At least one select bit, even for a single slave.
  function automatic int sel_w_f(input int n_slaves);
    return (n_slaves <= 2) ? 1 : $clog2(n_slaves);
  endfunction

endpackage

// File: rtl/iob_timeout_cnt.sv
// Per-transaction timeout counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart the count (transaction entering REQ)
//   en_i         : count this cycle (transaction in flight, clock enabled)
//   done_o       : this enabled cycle is the TIMEOUT-th one; tied 0 when TIMEOUT=0
module iob_timeout_cnt #(
  parameter int TIMEOUT = 255,
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // done fires on the enabled cycle that brings the count to TIMEOUT, so the
  // abort edge lands exactly TIMEOUT cycles after entry into REQ.
  if (TIMEOUT == 0) begin : g_no_timeout
    assign done_o = 1'b0;
  end else begin : g_timeout
    assign done_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/iob_native2iob_bridge.sv
// Bridge from a PicoRV32-style native memory port to N_SLAVES IOb slaves.
// Handshakes:
//   native side : mem_valid_i is held with stable addr/wdata/wstrb until the
//                 single-cycle mem_ready_o pulse; the request is sampled only
//                 in IDLE, so a valid still held during DONE/ERR is not
//                 re-issued.
//   IOb side    : s_avalid_o[sel] stays high in REQ until s_ready_i[sel];
//                 read data is taken on s_rvalid_i[sel] in RDATA only.
// Ports:
//   clk_i, rst_i, cke_i   : clock, sync active-high reset, clock enable
//   boot_i                : boot mode; instruction fetches go to slave 0
//   mem_*                 : native request / response
//   s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o : registered IOb request
//   s_ready_i, s_rvalid_i, s_rdata_i           : per-slave responses
//   err_o, err_addr_o     : error pulse and address of the last errored request
//   dbg_o                 : FSM state and latched instr flag
module iob_native2iob_bridge
  import iob_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int N_SLAVES   = 2,
  parameter int TIMEOUT    = 255,
  parameter int BOOT_REMAP = 1,
  localparam int SEL_W     = sel_w_f(N_SLAVES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cke_i,
  input  logic                         boot_i,
  input  logic                         mem_valid_i,
  input  logic                         mem_instr_i,
  input  logic [ADDR_W-1:0]            mem_addr_i,
  input  logic [DATA_W-1:0]            mem_wdata_i,
  input  logic [DATA_W/8-1:0]          mem_wstrb_i,
  output logic [DATA_W-1:0]            mem_rdata_o,
  output logic                         mem_ready_o,
  output logic [N_SLAVES-1:0]          s_avalid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  input  logic [N_SLAVES-1:0]          s_ready_i,
  input  logic [N_SLAVES-1:0]          s_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  output logic                         err_o,
  output logic [ADDR_W-1:0]            err_addr_o,
  output bridge_dbg_t                  dbg_o
);

  bridge_state_e       state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_in;
  logic [ADDR_W-1:0]   addr_q, err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   wdata_q, rdata_q, rdata_sel;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                instr_q;
  logic                decerr_in, ready_sel, rvalid_sel;
  logic                ld_req, cap_rdata, set_err;
  logic                tmo_clr, tmo_en, tmo_done;

  // Slave select from address MSBs; boot remap only affects instruction fetches.
  always_comb begin
    sel_in = mem_addr_i[ADDR_W-1 -: SEL_W];
    if ((BOOT_REMAP != 0) && boot_i && mem_instr_i) begin
      sel_in = '0;
    end
  end

  assign decerr_in = (32'(sel_in) >= N_SLAVES);

  // Only the selected slave's response is visible to the FSM.
  always_comb begin
    ready_sel  = 1'b0;
    rvalid_sel = 1'b0;
    rdata_sel  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        ready_sel  = s_ready_i[k];
        rvalid_sel = s_rvalid_i[k];
        rdata_sel  = s_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign tmo_clr = cke_i && (state_q == ST_IDLE) && mem_valid_i && !decerr_in;
  assign tmo_en  = cke_i && ((state_q == ST_REQ) || (state_q == ST_RDATA));

  iob_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tmo_clr),
    .en_i   (tmo_en),
    .done_o (tmo_done)
  );

  always_comb begin
    state_d    = state_q;
    ld_req     = 1'b0;
    cap_rdata  = 1'b0;
    set_err    = 1'b0;
    err_addr_d = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid_i) begin
          ld_req = 1'b1;
          if (decerr_in) begin
            state_d    = ST_ERR;
            set_err    = 1'b1;
            err_addr_d = mem_addr_i;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Timeout wins over a response arriving in the same cycle.
        if (tmo_done) begin
          state_d = ST_ERR;
          set_err = 1'b1;
        end else if (ready_sel) begin
          state_d = (wstrb_q != '0) ? ST_DONE : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (tmo_done) begin
          state_d = ST_ERR;
          set_err = 1'b1;
        end else if (rvalid_sel) begin
          cap_rdata = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      instr_q    <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (ld_req) begin
        sel_q   <= sel_in;
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        wstrb_q <= mem_wstrb_i;
        instr_q <= mem_instr_i;
        rdata_q <= '0;  // writes complete with zero read data
      end
      if (cap_rdata) begin
        rdata_q <= rdata_sel;
      end
      if (set_err) begin
        err_addr_q <= err_addr_d;
      end
    end
  end

  always_comb begin
    s_avalid_o = '0;
    if (state_q == ST_REQ) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        s_avalid_o[k] = (sel_q == SEL_W'(k));
      end
    end
  end

  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_wstrb_o   = wstrb_q;
  assign mem_ready_o = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err_o       = (state_q == ST_ERR);
  assign err_addr_o  = err_addr_q;
  assign mem_rdata_o = (state_q == ST_DONE) ? rdata_q :
                       (state_q == ST_ERR)  ? DATA_W'(DECERR_RDATA) : '0;
  assign dbg_o       = '{state: state_q, instr: instr_q};

endmodule

// File: doc/iob_native2iob_bridge.md
# iob_native2iob_bridge

Parametrised bridge from a PicoRV32-style native memory port (valid/ready held until ready) to N IOb slave ports selected by address MSBs. It sits between the CPU core wrapper and the peripheral/memory fabric. It generalises the single-channel instruction/data split to N_SLAVES channels and adds:
- a registered request FSM,
- write-ack generation,
- boot-time instruction remap,
- decode-error detection,
- a per-transaction timeout.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- N_SLAVES, 2, number of slave channels (1..8).
- SEL_W, derived localparam $clog2(N_SLAVES) (minimum 1); address MSBs used for selection.
- TIMEOUT, 255, cycles allowed in REQ+RDATA before abort; 0 disables the timeout.
- BOOT_REMAP, 1, enables forcing instruction fetches to slave 0 while boot_i=1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cke_i  in  1  clock enable; when 0, all state holds.
- boot_i  in  1  boot-mode flag.
- mem_valid_i  in  1  native request valid.
- mem_instr_i  in  1  request is an instruction fetch.
- mem_addr_i  in  ADDR_W  byte address.
- mem_wdata_i  in  DATA_W  write data.
- mem_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read.
- mem_rdata_o  out  DATA_W  read data; valid when mem_ready_o=1.
- mem_ready_o  out  1  one-cycle completion pulse.
- s_avalid_o  out  N_SLAVES  one-hot request valid.
- s_addr_o  out  ADDR_W  shared address, registered copy of mem_addr_i.
- s_wdata_o  out  DATA_W  shared write data, registered.
- s_wstrb_o  out  DATA_W/8  shared strobes, registered.
- s_ready_i  in  N_SLAVES  per-slave request accept.
- s_rvalid_i  in  N_SLAVES  per-slave read-data valid.
- s_rdata_i  in  N_SLAVES*DATA_W  concatenated read data; slave k occupies [k*DATA_W +: DATA_W].
- err_o  out  1  one-cycle pulse on decode error or timeout.
- err_addr_o  out  ADDR_W  address of the last errored request; held until the next error.

## Operation
FSM states: IDLE, REQ, RDATA, DONE, ERR.
- IDLE:
  - When mem_valid_i=1, latch addr/wdata/wstrb/instr.
  - Compute sel = mem_addr_i[ADDR_W-1 -: SEL_W]. If BOOT_REMAP and boot_i and mem_instr_i, sel=0.
  - If sel >= N_SLAVES, go to ERR (decode error). Otherwise go to REQ.
- REQ:
  - s_avalid_o[sel]=1; all other bits 0.
  - On s_ready_i[sel]=1: go to DONE if wstrb!=0 (write acked), else go to RDATA.
- RDATA: s_avalid_o=0. On s_rvalid_i[sel]=1, capture s_rdata_i slice into the rdata register and go to DONE.
- DONE: mem_ready_o=1, mem_rdata_o = captured data (0 for writes). Next state IDLE.
- ERR: mem_ready_o=1, mem_rdata_o=0, err_o=1, err_addr_o<=latched addr. Next state IDLE.
- Timeout counter:
  - Clears on entry to REQ and counts each enabled cycle in REQ/RDATA.
  - When it reaches TIMEOUT (TIMEOUT≠0), go to ERR regardless of the slave.
  - A late s_rvalid_i/s_ready_i arriving afterwards is ignored.
- Rules:
  - s_rvalid_i is sampled only in RDATA. Slaves must assert rvalid at least one cycle after ready.
  - Inputs from non-selected slaves are ignored.
  - No request is accepted in DONE or ERR. This prevents re-issuing a held mem_valid_i in its completion cycle.

## Timing
- Reset value of every output is 0; state=IDLE; counter=0; err_addr_o=0.
- Reset has priority over cke_i. Reset mid-transaction drops the request and leaves no slave avalid asserted in the next cycle.
- Read, zero-wait slave (edge 0 = IDLE samples mem_valid_i):
  - s_avalid_o high in cycle 1, with ready the same cycle.
  - rvalid in cycle 2.
  - mem_ready_o in cycle 3.
  - Total latency 3 cycles from valid to ready.
- Write, zero-wait slave: mem_ready_o in cycle 2.
- Decode error: mem_ready_o and err_o in cycle 1.
- Timeout: ERR entered TIMEOUT cycles after REQ entry; mem_ready_o and err_o then pulse one cycle.
- Back-to-back: the next request can be sampled in the cycle after DONE/ERR, giving a minimum issue interval of 4 cycles for reads and 3 for writes.
- cke_i=0 freezes state, counter and all registered outputs. A mem_ready_o pulse is stretched while cke_i=0.

## Structure
- Shared package iob_bridge_pkg holds:
  - state encoding localparams (IDLE=0 … ERR=4),
  - DECERR_RDATA constant (0),
  - the SEL_W derivation function.
- Sub-module iob_timeout_cnt: counter with clr/en/done, width $clog2(TIMEOUT+1), done tied 0 when TIMEOUT=0.
- All registers are in the bridge, using the codebase register primitive with synchronous reset.

## Test plan
- Read slave 1, addr 0x8000_0010, slave returns 0xCAFE_F00D one cycle after ready -> mem_ready_o in cycle 3 with rdata 0xCAFE_F00D; s_avalid_o=2'b10 for exactly one cycle.
- Write slave 0, wstrb 4'b0011, data 0x1234_5678 -> s_wstrb_o=0011, s_wdata_o=0x1234_5678; mem_ready_o in cycle 2; err_o stays 0.
- N_SLAVES=3, addr 0xC000_0000 -> decode error: mem_ready_o and err_o in cycle 1, rdata 0, err_addr_o=0xC000_0000, no avalid.
- boot_i=1, instr fetch at 0x8000_0000 -> s_avalid_o=3'b001. Same fetch with boot_i=0 -> s_avalid_o=3'b100.
- TIMEOUT=4, slave never asserts ready -> ERR after 4 REQ cycles; err_o pulse; a later s_ready_i is ignored and the next request completes normally.
- Assert rst_i while in RDATA -> next cycle all outputs 0 and state IDLE; a held mem_valid_i is reissued from scratch after reset.
